// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - default geometry constants
//   - write-port indices (ALU writeback, load writeback)
//   - byte-merge helper used by both the storage update and the read bypass
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int NUM_WP  = 2;
  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;

  // The merge helper works on the widest supported word; callers extend and
  // truncate to their own DATA_W.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_val,
    input logic [MAX_DATA_W-1:0] new_val,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_val;
    for (int k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
//   rd_addr/rd_data/rd_busy : NUM_RD packed read ports
//   we*/wa*/wd*/wbe*        : write port 0 (ALU) and 1 (load), byte-enabled
//   alloc_en/alloc_addr     : mark a load destination pending
//   pend_any                : any register pending
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa0;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd0;
  logic [DATA_W-1:0]        wd1;
  logic [BE_W-1:0]          wbe0;
  logic [BE_W-1:0]          wbe1;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     pend_any;

  modport master (
    output rd_addr, we0, we1, wa0, wa1, wd0, wd1, wbe0, wbe1, alloc_en, alloc_addr,
    input  rd_data, rd_busy, pend_any
  );

  modport slave (
    input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, wbe0, wbe1, alloc_en, alloc_addr,
    output rd_data, rd_busy, pend_any
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard.
//   clk, clrn            : clock, async active-low reset
//   alloc_en, alloc_addr : set pending for a load destination
//   clr_en, clr_addr     : load writeback landing (we1 with nonzero byte enables)
//   rd_addr              : packed read addresses
//   rd_busy              : per read port, pending and not landing this cycle
//   pend_any             : OR of all pending bits
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     pend_any
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend;
  logic             alloc_ok;

  assign alloc_ok = alloc_en && !(ZERO_REG && alloc_addr == '0);

  // The set is written after the clear so a new producer allocated on the
  // same edge the old load lands keeps the register pending.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend <= '0;
    end else begin
      if (clr_en)   pend[clr_addr]   <= 1'b0;
      if (alloc_ok) pend[alloc_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    // A load landing on this register this cycle is bypassed, so no stall.
    assign rd_busy[i] = clrn && pend[ra] && !(clr_en && clr_addr == ra);
  end

  assign pend_any = clrn && (|pend);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-enabled ALU/load write ports,
// same-cycle write-to-read bypass and a pending-load scoreboard.
//   clk, clrn : clock, async active-low reset
//   bus       : regfile_mp_if slave modport (reads, writes, alloc, status)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];

  logic              wp_en   [NUM_WP];
  logic [ADDR_W-1:0] wp_addr [NUM_WP];
  logic [DATA_W-1:0] wp_data [NUM_WP];
  logic [BE_W-1:0]   wp_be   [NUM_WP];

  assign wp_en[WP_ALU]    = bus.we0;
  assign wp_addr[WP_ALU]  = bus.wa0;
  assign wp_data[WP_ALU]  = bus.wd0;
  assign wp_be[WP_ALU]    = bus.wbe0;
  assign wp_en[WP_LOAD]   = bus.we1;
  assign wp_addr[WP_LOAD] = bus.wa1;
  assign wp_data[WP_LOAD] = bus.wd1;
  assign wp_be[WP_LOAD]   = bus.wbe1;

  function automatic logic [DATA_W-1:0] merge_w(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] wide;
    wide = merge_bytes(MAX_DATA_W'(old_val), MAX_DATA_W'(new_val), MAX_BE_W'(be));
    return wide[DATA_W-1:0];
  endfunction

  // Byte enables a write port applies to register a (zero if not targeted).
  function automatic logic [BE_W-1:0] port_mask(input int p, input logic [ADDR_W-1:0] a);
    return (wp_en[p] && wp_addr[p] == a) ? wp_be[p] : '0;
  endfunction

  // Ports are merged in index order so the load port wins overlapping bytes.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_nxt[r] = mem[r];
      for (int p = 0; p < NUM_WP; p++) begin
        mem_nxt[r] = merge_w(mem_nxt[r], wp_data[p], port_mask(p, ADDR_W'(r)));
      end
      if (ZERO_REG && r == 0) mem_nxt[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      mem <= mem_nxt;
    end
  end

  logic [DATA_W-1:0] rd_word [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp;
    assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign byp = merge_w(merge_w(mem[ra], wp_data[WP_ALU], port_mask(WP_ALU, ra)),
                         wp_data[WP_LOAD], port_mask(WP_LOAD, ra));
    // Reset forces zero so an in-flight write cannot leak through the bypass.
    assign rd_word[i] = (!clrn || (ZERO_REG && ra == '0)) ? '0 : byp;
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) bus.rd_data[i*DATA_W +: DATA_W] = rd_word[i];
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .clrn       (clrn),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .clr_en     (bus.we1 && (|bus.wbe1)),
    .clr_addr   (bus.wa1),
    .rd_addr    (bus.rd_addr),
    .rd_busy    (bus.rd_busy),
    .pend_any   (bus.pend_any)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk;
  logic clrn;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [31:0] rd0 = bus.rd_data[31:0];
  wire [31:0] rd1 = bus.rd_data[63:32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0; bus.wbe0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0; bus.wbe1 = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.we0 = 1'b1; bus.wa0 = a; bus.wd0 = d; bus.wbe0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.we1 = 1'b1; bus.wa1 = a; bus.wd1 = d; bus.wbe1 = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: outputs zero even with a write to the read address
    clrn = 1'b0;
    idle(); rd(5'd5, 5'd0);
    wr0(5'd5, 32'hDEADBEEF, 4'hF);
    #3;
    check("rst_rd_data", rd0, 32'h0);
    check("rst_busy", {30'b0, bus.rd_busy}, 32'h0);
    check("rst_pend_any", {31'b0, bus.pend_any}, 32'h0);
    @(negedge clk); clrn = 1'b1; idle();

    // Write r5, alloc r6, then pulse reset between edges
    @(negedge clk); wr0(5'd5, 32'hDEADBEEF, 4'hF); bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
    @(negedge clk); idle(); rd(5'd5, 5'd6);
    #1;
    check("r5_stored", rd0, 32'hDEADBEEF);
    check("r6_busy", {31'b0, bus.rd_busy[1]}, 32'h1);
    check("pend_any_set", {31'b0, bus.pend_any}, 32'h1);
    #1 clrn = 1'b0;
    #1;
    check("midrst_r5", rd0, 32'h0);
    check("midrst_pend_any", {31'b0, bus.pend_any}, 32'h0);
    #1 clrn = 1'b1;
    @(negedge clk); #1;
    check("postrst_r5", rd0, 32'h0);
    check("postrst_r6_busy", {31'b0, bus.rd_busy[1]}, 32'h0);

    // Port 0 bypass and storage
    @(negedge clk); idle(); rd(5'd7, 5'd7); wr0(5'd7, 32'h11111111, 4'hF);
    #1 check("byp_p0", rd0, 32'h11111111);
    @(negedge clk); idle();
    #1 check("stored_p0", rd0, 32'h11111111);

    // Collision: port 1 owns its enabled bytes, port 0 the rest
    @(negedge clk); wr0(5'd7, 32'h33333333, 4'hF); wr1(5'd7, 32'h22222222, 4'h3);
    #1 check("byp_collide", rd1, 32'h33332222);
    @(negedge clk); idle();
    #1 check("stored_collide", rd1, 32'h33332222);

    // Byte enable on port 0
    @(negedge clk); rd(5'd3, 5'd7); wr0(5'd3, 32'hAABBCCDD, 4'hF);
    @(negedge clk); idle(); wr0(5'd3, 32'h00000011, 4'h1);
    #1 check("byp_be", rd0, 32'hAABBCC11);
    @(negedge clk); idle();
    #1 check("stored_be", rd0, 32'hAABBCC11);

    // Byte enable on port 1, upper byte only
    @(negedge clk); wr1(5'd3, 32'h77000000, 4'h8);
    #1 check("byp_be1", rd0, 32'h77BBCC11);
    @(negedge clk); idle();

    // Zero register: write and alloc ignored
    @(negedge clk); rd(5'd0, 5'd0); wr0(5'd0, 32'h5, 4'hF); bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    #1 check("r0_byp", rd0, 32'h0);
    @(negedge clk); idle();
    #1;
    check("r0_stored", rd1, 32'h0);
    check("r0_pend_any", {31'b0, bus.pend_any}, 32'h0);
    check("r0_busy", {30'b0, bus.rd_busy}, 32'h0);

    // Scoreboard: alloc r9 takes effect after the edge
    @(negedge clk); rd(5'd0, 5'd9); bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    #1 check("alloc_same_cycle", {31'b0, bus.rd_busy[1]}, 32'h0);
    @(negedge clk); idle();
    #1;
    check("alloc_busy", {31'b0, bus.rd_busy[1]}, 32'h1);
    check("alloc_pend_any", {31'b0, bus.pend_any}, 32'h1);

    // Port 0 write does not clear
    @(negedge clk); wr0(5'd9, 32'h55, 4'hF);
    #1 check("p0_busy_in", {31'b0, bus.rd_busy[1]}, 32'h1);
    @(negedge clk); idle();
    #1 check("p0_busy_after", {31'b0, bus.rd_busy[1]}, 32'h1);

    // Load lands: bypassed, no stall, then cleared
    @(negedge clk); wr1(5'd9, 32'h00001234, 4'hF);
    #1;
    check("land_busy", {31'b0, bus.rd_busy[1]}, 32'h0);
    check("land_data", rd1, 32'h00001234);
    @(negedge clk); idle();
    #1;
    check("land_busy_after", {31'b0, bus.rd_busy[1]}, 32'h0);
    check("land_pend_any", {31'b0, bus.pend_any}, 32'h0);
    check("land_stored", rd1, 32'h00001234);

    // Set beats clear on the same edge
    @(negedge clk); rd(5'd4, 5'd9); bus.alloc_en = 1'b1; bus.alloc_addr = 5'd4; wr1(5'd4, 32'h0000CAFE, 4'hF);
    #1 check("sbc_busy_in", {31'b0, bus.rd_busy[0]}, 32'h0);
    @(negedge clk); idle();
    #1;
    check("sbc_data", rd0, 32'h0000CAFE);
    check("sbc_busy", {31'b0, bus.rd_busy[0]}, 32'h1);

    // Load write with zero byte enables neither bypasses nor clears
    @(negedge clk); wr1(5'd4, 32'hFFFFFFFF, 4'h0);
    #1 check("zbe_busy_in", {31'b0, bus.rd_busy[0]}, 32'h1);
    @(negedge clk); idle();
    #1;
    check("zbe_busy_after", {31'b0, bus.rd_busy[0]}, 32'h1);
    check("zbe_data", rd0, 32'h0000CAFE);

    // Real landing clears
    @(negedge clk); wr1(5'd4, 32'h0000BEEF, 4'h3);
    @(negedge clk); idle();
    #1;
    check("final_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    check("final_data", rd0, 32'h0000BEEF);
    check("final_pend_any", {31'b0, bus.pend_any}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
